// File: rtl/ssp_tx_ljustify_buf.sv
// SSP transmit left-justifier with a DEPTH-entry output buffer; config snapshotted per accepted word.
// Latency: word accepted at edge k is presented on OUT_* after edge k (no empty bypass).
// Backpressure: IN_READY = (count<DEPTH) & ~PRESET from registered count; OUT_* hold while OUT_VALID & ~OUT_READY.
// Optional macro SSP_TX_LSBFIRST_EN builds LSB-first bit reversal driven by LSBFIRST.
module ssp_tx_ljustify_buf #(
  parameter int DATA_W = 16,
  parameter int DSS_W  = 4,
  parameter int MW_W   = 8,
  parameter int DEPTH  = 2
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              FLUSH,
  input  logic [1:0]        FRF,
  input  logic [DSS_W-1:0]  DSS,
  input  logic              MS,
  input  logic              LSBFIRST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [DSS_W-1:0]  OUT_LEN,
  output logic              OUT_ERR
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DSS_W-1:0]  len;
    logic              err;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  entry_t             head_q, head_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               mw_master;
  logic               rsv;
  int                 dss_val;
  int                 n_eff;
  logic [DATA_W-1:0]  just;
  entry_t             in_entry;
  logic               push;
  logic               pop;

`ifdef SSP_TX_LSBFIRST_EN
  logic [DATA_W-1:0]  rev;
`else
  // Port kept for interface compatibility; MSB-first only in this build.
  logic               unused_lsbfirst;
  assign unused_lsbfirst = LSBFIRST;
`endif

  // Handshake: ready is derived purely from the registered occupancy.
  assign IN_READY  = (count_q < CNT_W'(DEPTH)) && !PRESET;
  assign OUT_VALID = (count_q != '0);
  assign push      = IN_VALID && IN_READY && !FLUSH;
  assign pop       = OUT_VALID && OUT_READY;

  assign OUT_DATA  = head_q.data;
  assign OUT_LEN   = head_q.len;
  assign OUT_ERR   = head_q.err;

  // Snapshot config for the incoming word: effective size, reserved check, justify.
  always_comb begin
    dss_val   = int'(DSS);
    mw_master = (FRF == 2'b10) && !MS;
    n_eff     = mw_master ? MW_W : dss_val + 1;
    rsv       = !mw_master && ((dss_val < 3) || (dss_val + 1 > DATA_W));
    // Left shift drops every bit above n-1 and zero-fills the low bits.
    just      = IN_DATA << (DATA_W - n_eff);
`ifdef SSP_TX_LSBFIRST_EN
    rev = '0;
    for (int i = 0; i < DATA_W; i++) begin
      rev[DATA_W-1-i] = IN_DATA[i];
    end
    // Reversed word already has IN_DATA[0] at the MSB; keep only the top n bits.
    if (LSBFIRST) begin
      just = rev & ~({DATA_W{1'b1}} >> n_eff);
    end
`endif
    in_entry.data = rsv ? '0 : just;
    in_entry.len  = rsv ? '0 : DSS_W'(n_eff - 1);
    in_entry.err  = rsv;
  end

  // Next-state for buffer storage, pointers, count and the registered head.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;

    if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end

    // Head register tracks the next entry; when empty it keeps the last word.
    if (count_d != '0) begin
      head_d = mem_d[rd_ptr_d];
    end
  end

  // State update with synchronous reset; reset also clears the presented word.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_ssp_tx_ljustify_buf.sv
// Directed bench for ssp_tx_ljustify_buf: vector table for the justify path,
// hand-written sequences for reset, backpressure, concurrent push/pop and flush.
module tb_ssp_tx_ljustify_buf;

  logic        PCLK = 1'b0;
  logic        PRESET, FLUSH, MS, LSBFIRST, IN_VALID, OUT_READY;
  logic [1:0]  FRF;
  logic [3:0]  DSS;
  logic [15:0] IN_DATA;
  logic        IN_READY, OUT_VALID, OUT_ERR;
  logic [15:0] OUT_DATA;
  logic [3:0]  OUT_LEN;

  int n_chk = 0;
  int n_err = 0;

  ssp_tx_ljustify_buf #(.DATA_W(16), .DSS_W(4), .MW_W(8), .DEPTH(2)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .FLUSH(FLUSH), .FRF(FRF), .DSS(DSS), .MS(MS),
    .LSBFIRST(LSBFIRST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .OUT_LEN(OUT_LEN), .OUT_ERR(OUT_ERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [1:0]  frf;
    logic [3:0]  dss;
    logic        ms;
    logic        lsb;
    logic [15:0] din;
    logic [15:0] exp_data;
    logic [3:0]  exp_len;
    logic        exp_err;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic push_word(input logic [3:0] dss, input logic [15:0] d);
    DSS = dss; IN_DATA = d; IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{2'b00, 4'h3, 1'b0, 1'b0, 16'hFFFA, 16'hA000, 4'd3,  1'b0};
    vecs[1]  = '{2'b10, 4'hF, 1'b0, 1'b0, 16'h12C5, 16'hC500, 4'd7,  1'b0};
    vecs[2]  = '{2'b10, 4'hF, 1'b1, 1'b0, 16'h12C5, 16'h12C5, 4'd15, 1'b0};
    vecs[3]  = '{2'b00, 4'h1, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 4'd0,  1'b1};
`ifdef SSP_TX_LSBFIRST_EN
    vecs[4]  = '{2'b00, 4'h7, 1'b0, 1'b1, 16'h0001, 16'h8000, 4'd7,  1'b0};
    vecs[10] = '{2'b00, 4'h3, 1'b0, 1'b1, 16'h0003, 16'hC000, 4'd3,  1'b0};
`else
    vecs[4]  = '{2'b00, 4'h7, 1'b0, 1'b1, 16'h0001, 16'h0100, 4'd7,  1'b0};
    vecs[10] = '{2'b00, 4'h3, 1'b0, 1'b1, 16'h0003, 16'h3000, 4'd3,  1'b0};
`endif
    vecs[5]  = '{2'b00, 4'h2, 1'b0, 1'b0, 16'h1234, 16'h0000, 4'd0,  1'b1};
    vecs[6]  = '{2'b00, 4'hB, 1'b0, 1'b0, 16'hABCD, 16'hBCD0, 4'd11, 1'b0};
    vecs[7]  = '{2'b01, 4'h7, 1'b0, 1'b0, 16'h00A5, 16'hA500, 4'd7,  1'b0};
    vecs[8]  = '{2'b10, 4'h2, 1'b0, 1'b0, 16'h0081, 16'h8100, 4'd7,  1'b0};
    vecs[9]  = '{2'b00, 4'h4, 1'b0, 1'b0, 16'h0013, 16'h9800, 4'd4,  1'b0};

    PRESET = 1'b1; FLUSH = 1'b0; FRF = 2'b00; DSS = 4'hF; MS = 1'b0; LSBFIRST = 1'b0;
    IN_VALID = 1'b1; IN_DATA = 16'h5555; OUT_READY = 1'b0;

    // Reset held two cycles with IN_VALID asserted.
    step();
    step();
    chk("rst_in_ready", IN_READY, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_out_data", OUT_DATA, 16'h0000);
    chk("rst_out_len", OUT_LEN, 0);
    chk("rst_out_err", OUT_ERR, 0);
    PRESET = 1'b0; IN_VALID = 1'b0;
    step();
    chk("post_rst_out_valid", OUT_VALID, 0);
    chk("post_rst_in_ready", IN_READY, 1);

    // Justify vectors: accept, see word one cycle later, pop it.
    OUT_READY = 1'b1;
    for (int i = 0; i < 11; i++) begin
      FRF = vecs[i].frf; DSS = vecs[i].dss; MS = vecs[i].ms; LSBFIRST = vecs[i].lsb;
      IN_DATA = vecs[i].din; IN_VALID = 1'b1;
      chk($sformatf("v%0d_in_ready", i), IN_READY, 1);
      step();
      IN_VALID = 1'b0;
      chk($sformatf("v%0d_valid", i), OUT_VALID, 1);
      chk($sformatf("v%0d_data", i), OUT_DATA, vecs[i].exp_data);
      chk($sformatf("v%0d_len", i), OUT_LEN, vecs[i].exp_len);
      chk($sformatf("v%0d_err", i), OUT_ERR, vecs[i].exp_err);
      step();
      chk($sformatf("v%0d_drained", i), OUT_VALID, 0);
    end
    FRF = 2'b00; MS = 1'b0; LSBFIRST = 1'b0;

    // Backpressure: fill both entries, then pop at full while offering another word.
    OUT_READY = 1'b0;
    push_word(4'hF, 16'h0001);
    chk("bp1_valid", OUT_VALID, 1);
    chk("bp1_data", OUT_DATA, 16'h0001);
    chk("bp1_in_ready", IN_READY, 1);
    push_word(4'hF, 16'h0002);
    chk("bp_full_in_ready", IN_READY, 0);
    step();
    chk("bp_hold_data", OUT_DATA, 16'h0001);
    chk("bp_hold_len", OUT_LEN, 15);
    OUT_READY = 1'b1; IN_VALID = 1'b1; IN_DATA = 16'h0003;
    chk("bp_full_pop_in_ready", IN_READY, 0);
    step();
    IN_VALID = 1'b0;
    chk("bp_pop2_valid", OUT_VALID, 1);
    chk("bp_pop2_data", OUT_DATA, 16'h0002);
    chk("bp_after_pop_in_ready", IN_READY, 1);
    step();
    chk("bp_empty_valid", OUT_VALID, 0);
    chk("bp_empty_keeps_data", OUT_DATA, 16'h0002);

    // Push and pop together at count 1 keeps one word, now the newer one.
    OUT_READY = 1'b0;
    push_word(4'hF, 16'h0005);
    OUT_READY = 1'b1; IN_VALID = 1'b1; IN_DATA = 16'h0006;
    step();
    IN_VALID = 1'b0;
    chk("pp_valid", OUT_VALID, 1);
    chk("pp_data", OUT_DATA, 16'h0006);
    step();
    chk("pp_drained", OUT_VALID, 0);

    // Config change mid-stream only affects later words.
    OUT_READY = 1'b0;
    push_word(4'hF, 16'h00F3);
    push_word(4'h3, 16'h00F3);
    OUT_READY = 1'b1;
    chk("cfg_w1_data", OUT_DATA, 16'h00F3);
    chk("cfg_w1_len", OUT_LEN, 15);
    step();
    chk("cfg_w2_data", OUT_DATA, 16'h3000);
    chk("cfg_w2_len", OUT_LEN, 3);
    step();
    chk("cfg_drained", OUT_VALID, 0);

    // Flush while full: nothing emerges afterwards.
    OUT_READY = 1'b0;
    push_word(4'hF, 16'h0007);
    push_word(4'hF, 16'h0008);
    FLUSH = 1'b1; IN_VALID = 1'b1; IN_DATA = 16'h0009;
    step();
    FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    chk("fl_full_valid", OUT_VALID, 0);
    chk("fl_full_in_ready", IN_READY, 1);
    step();
    step();
    chk("fl_full_stays_empty", OUT_VALID, 0);

    // Flush with a concurrent push at empty discards the push.
    FLUSH = 1'b1; IN_VALID = 1'b1; IN_DATA = 16'h000A;
    step();
    FLUSH = 1'b0; IN_VALID = 1'b0;
    chk("fl_push_discarded", OUT_VALID, 0);

    // Mid-operation reset clears buffer and presented word, wins over FLUSH.
    OUT_READY = 1'b0;
    push_word(4'hF, 16'hBEEF);
    chk("mr_pre_data", OUT_DATA, 16'hBEEF);
    PRESET = 1'b1; FLUSH = 1'b1;
    step();
    chk("mr_in_ready", IN_READY, 0);
    PRESET = 1'b0; FLUSH = 1'b0;
    chk("mr_valid", OUT_VALID, 0);
    chk("mr_data", OUT_DATA, 16'h0000);
    chk("mr_len", OUT_LEN, 0);
    push_word(4'h3, 16'h0009);
    chk("mr_after_data", OUT_DATA, 16'h9000);
    chk("mr_after_valid", OUT_VALID, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
